sdram_port_arbiter: RTL and testbench

Two-port round-robin arbiter in front of the sdram_controller user interface (user_addr/rw/data_in/data_out/busy/in_valid/out_valid).
- Port m0 is the Wishbone-side requester; port m1 is a secondary master (DMA/prefetch engine).
- One transaction is in flight at a time; the controller drives the SDRAM model/pins as before.
- The arbiter sequences the controller handshakes and returns per-port acks and read data.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_rr_pick.sv | 21 ++
 rtl/sdram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the two-port SDRAM arbiter: FSM states, port indices
// and the fill word returned when a read is abandoned by the watchdog.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-input round-robin selector: a lone requester wins outright; on a tie
// the port that was not served last wins. Output is one-hot, 0 when idle.
module sdram_rr_pick
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] sel
);

  always_comb begin
    sel = 2'b00;
    case (req)
      2'b01:   sel = 2'b01;
      2'b10:   sel = 2'b10;
      2'b11:   sel = (last == PORT_M0) ? 2'b10 : 2'b01;
      default: sel = 2'b00;
    endcase
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the sdram_controller user interface.
// Optional read watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_sel,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_sel,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,

  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [DATA_W-1:0] ctrl_wdata,
  output logic [3:0]        ctrl_sel,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic              ctrl_out_valid,
  input  logic [DATA_W-1:0] ctrl_rdata,

  output logic [1:0]        grant,
  output logic              timeout_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sdram_port_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t        state, state_n;
  logic              last;
  logic [1:0]        pick;
  logic              accept;
  logic              rd_timeout;
  logic              rd_done;
  logic [DATA_W-1:0] rd_value;

  sdram_rr_pick u_pick (
    .req  ({m1_req, m0_req}),
    .last (last),
    .sel  (pick)
  );

  assign ctrl_in_valid = (state == ISSUE);
  assign accept        = ctrl_in_valid & ~ctrl_busy;
  assign m0_ack        = (state == ACK) & grant[0];
  assign m1_ack        = (state == ACK) & grant[1];

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             tmo_flag;

  // A real completion in the same cycle as expiry wins over the fill word.
  assign rd_timeout = (state == WAIT_RD) & ~ctrl_out_valid &
                      (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign rd_value   = ctrl_out_valid ? ctrl_rdata : DATA_W'(TIMEOUT_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == WAIT_RD) wd_cnt <= wd_cnt + 1'b1;
      else                  wd_cnt <= '0;
      if (rd_timeout)       tmo_flag <= 1'b1;
    end
  end

  assign timeout_err = tmo_flag;
`else
  assign rd_timeout  = 1'b0;
  assign rd_value    = ctrl_rdata;
  assign timeout_err = 1'b0;
`endif

  assign rd_done = (state == WAIT_RD) & (ctrl_out_valid | rd_timeout);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|pick)   state_n = ISSUE;
      ISSUE:   if (accept)  state_n = ctrl_rw ? ACK : WAIT_RD;
      WAIT_RD: if (rd_done) state_n = ACK;
      ACK:                  state_n = IDLE;
      default:              state_n = IDLE;
    endcase
  end

  // Request capture happens only on the IDLE edge, so a requester may change
  // or drop its inputs while its transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= PORT_M1;
      grant      <= 2'b00;
      ctrl_addr  <= '0;
      ctrl_rw    <= 1'b0;
      ctrl_wdata <= '0;
      ctrl_sel   <= 4'h0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && (|pick)) begin
        grant      <= pick;
        ctrl_addr  <= pick[1] ? m1_addr  : m0_addr;
        ctrl_rw    <= pick[1] ? m1_we    : m0_we;
        ctrl_wdata <= pick[1] ? m1_wdata : m0_wdata;
        ctrl_sel   <= pick[1] ? m1_sel   : m0_sel;
      end
      if (state == ACK) begin
        grant <= 2'b00;
        last  <= grant[1];
      end
    end
  end

  // Read data is steered to the owning port and held until its next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (rd_done) begin
      if (grant[0]) m0_rdata <= rd_value;
      if (grant[1]) m1_rdata <= rd_value;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: the bench plays both masters and
// the SDRAM controller, predicting grants, acks and read data from a small model.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;

  logic              p_req   [2];
  logic              p_we    [2];
  logic [3:0]        p_sel   [2];
  logic [ADDR_W-1:0] p_addr  [2];
  logic [DATA_W-1:0] p_wdata [2];

  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_rw;
  logic [DATA_W-1:0] ctrl_wdata;
  logic [3:0]        ctrl_sel;
  logic              ctrl_in_valid;
  logic              ctrl_busy = 1'b0;
  logic              ctrl_out_valid = 1'b0;
  logic [DATA_W-1:0] ctrl_rdata = '0;
  logic [1:0]        grant;
  logic              timeout_err;

  logic [1:0]        acks;
  logic [DATA_W-1:0] rd_out [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: port served last, and each port's last read word.
  int                last_srv = 1;
  logic [DATA_W-1:0] exp_rd [2];

  assign acks      = {m1_ack, m0_ack};
  assign rd_out[0] = m0_rdata;
  assign rd_out[1] = m1_rdata;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req         (p_req[0]),
    .m0_we          (p_we[0]),
    .m0_sel         (p_sel[0]),
    .m0_addr        (p_addr[0]),
    .m0_wdata       (p_wdata[0]),
    .m0_ack         (m0_ack),
    .m0_rdata       (m0_rdata),
    .m1_req         (p_req[1]),
    .m1_we          (p_we[1]),
    .m1_sel         (p_sel[1]),
    .m1_addr        (p_addr[1]),
    .m1_wdata       (p_wdata[1]),
    .m1_ack         (m1_ack),
    .m1_rdata       (m1_rdata),
    .ctrl_addr      (ctrl_addr),
    .ctrl_rw        (ctrl_rw),
    .ctrl_wdata     (ctrl_wdata),
    .ctrl_sel       (ctrl_sel),
    .ctrl_in_valid  (ctrl_in_valid),
    .ctrl_busy      (ctrl_busy),
    .ctrl_out_valid (ctrl_out_valid),
    .ctrl_rdata     (ctrl_rdata),
    .grant          (grant),
    .timeout_err    (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [3:0] sel);
    p_req[p]   = 1'b1;
    p_we[p]    = we;
    p_addr[p]  = addr;
    p_wdata[p] = wdata;
    p_sel[p]   = sel;
  endtask

  task automatic load_port(input int p);
    set_port(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, 4'($urandom));
  endtask

  function automatic int model_pick();
    if (p_req[0] && p_req[1]) return (last_srv == 0) ? 1 : 0;
    if (p_req[1]) return 1;
    return 0;
  endfunction

  // Runs one transaction from IDLE. mode 0: drop req after ack; 1: drop req
  // while the op is in flight; 2: keep requesting with a fresh op after ack.
  task automatic transact(input int nb, input int dly, input int mode,
                          input logic [DATA_W-1:0] rval);
    int                w, o;
    logic [1:0]        oh;
    logic              e_we;
    logic [3:0]        e_sel;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    w       = model_pick();
    o       = 1 - w;
    oh      = (w == 1) ? 2'b10 : 2'b01;
    e_we    = p_we[w];
    e_sel   = p_sel[w];
    e_addr  = p_addr[w];
    e_wdata = p_wdata[w];
    tick();
    check("grant", grant, oh);
    check("issue_valid", ctrl_in_valid, 1);
    check("issue_addr", ctrl_addr, e_addr);
    check("issue_rw", ctrl_rw, e_we);
    check("issue_wdata", ctrl_wdata, e_wdata);
    check("issue_sel", ctrl_sel, e_sel);
    if (mode == 1) p_req[w] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      ctrl_busy  = 1'b1;
      p_addr[w]  = ADDR_W'($urandom);
      p_wdata[w] = $urandom;
      tick();
      check("busy_valid", ctrl_in_valid, 1);
      check("busy_addr", ctrl_addr, e_addr);
      check("busy_wdata", ctrl_wdata, e_wdata);
      check("busy_noack", acks, 0);
    end
    ctrl_busy = 1'b0;
    tick();
    if (e_we) begin
      check("wr_ack", acks, oh);
    end else begin
      check("rd_valid_drop", ctrl_in_valid, 0);
      for (int i = 0; i < dly; i++) begin
        check("rd_wait_noack", acks, 0);
        tick();
      end
      ctrl_out_valid = 1'b1;
      ctrl_rdata     = rval;
      tick();
      ctrl_out_valid = 1'b0;
      ctrl_rdata     = $urandom;
      check("rd_ack", acks, oh);
      exp_rd[w] = rval;
    end
    check("rdata_own", rd_out[w], exp_rd[w]);
    check("rdata_other", rd_out[o], exp_rd[o]);
    last_srv = w;
    if (mode == 2) load_port(w);
    else           p_req[w] = 1'b0;
    tick();
    check("idle_grant", grant, 0);
    check("idle_noack", acks, 0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      p_req[p]   = 1'b0;
      p_we[p]    = 1'b0;
      p_sel[p]   = 4'h0;
      p_addr[p]  = '0;
      p_wdata[p] = '0;
      exp_rd[p]  = '0;
    end

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_acks", acks, 0);
    check("rst_valid", ctrl_in_valid, 0);
    check("rst_rw", ctrl_rw, 0);
    check("rst_addr", ctrl_addr, 0);
    check("rst_wdata", ctrl_wdata, 0);
    check("rst_sel", ctrl_sel, 0);
    check("rst_rdata0", m0_rdata, 0);
    check("rst_rdata1", m1_rdata, 0);
    check("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    tick();
    check("idle_grant0", grant, 0);

    // m0 write, controller ready immediately
    set_port(0, 1'b1, ADDR_W'(32'h10), 32'hA5A5_0001, 4'hF);
    transact(0, 0, 0, '0);

    // m1 read, out_valid five cycles after accept
    set_port(1, 1'b0, ADDR_W'(32'h20), 32'h0, 4'hF);
    transact(0, 4, 0, 32'h1234_5678);
    check("m1_rdata_dir", m1_rdata, 32'h1234_5678);

    // Both ports requesting continuously: grants must alternate
    load_port(0);
    load_port(1);
    for (int k = 0; k < 8; k++)
      transact($urandom_range(0, 3), $urandom_range(0, 6), 2, $urandom);
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    tick();
    check("drained_grant", grant, 0);

    // Controller busy for seven cycles
    set_port(0, 1'b1, ADDR_W'(32'h44), 32'hCAFE_0007, 4'h3);
    transact(7, 0, 0, '0);

    // Request withdrawn mid-transaction still completes
    set_port(1, 1'b0, ADDR_W'(32'h88), 32'h0, 4'hC);
    transact(2, 3, 1, 32'h0BAD_F00D);

    // Randomised mix of single and contending requests
    for (int k = 0; k < 24; k++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && ($urandom_range(0, 1) == 1)) load_port(p);
      if (!p_req[0] && !p_req[1]) load_port($urandom_range(0, 1));
      transact($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1), $urandom);
    end
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    tick();

    // out_valid while idle is ignored
    ctrl_out_valid = 1'b1;
    ctrl_rdata     = 32'hFFFF_0000;
    tick();
    ctrl_out_valid = 1'b0;
    check("stray_ov_ack", acks, 0);
    check("stray_ov_grant", grant, 0);
    check("stray_ov_rd0", m0_rdata, exp_rd[0]);
    check("stray_ov_rd1", m1_rdata, exp_rd[1]);

    // Reset while waiting on a read abandons it
    set_port(0, 1'b0, ADDR_W'(32'h300), 32'h0, 4'hF);
    tick();
    tick();
    tick();
    check("pre_rst_wait", ctrl_in_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p_req[0] = 1'b0;
    last_srv = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_acks", acks, 0);
    check("mid_rst_addr", ctrl_addr, 0);
    check("mid_rst_rd0", m0_rdata, 0);
    ctrl_out_valid = 1'b1;
    ctrl_rdata     = 32'h5555_AAAA;
    tick();
    ctrl_out_valid = 1'b0;
    check("post_rst_ack", acks, 0);
    check("post_rst_grant", grant, 0);
    check("post_rst_rd0", m0_rdata, 0);
    tick();
    check("post_rst_ack2", acks, 0);
    set_port(0, 1'b0, ADDR_W'(32'h304), 32'h0, 4'hF);
    transact(0, 2, 0, 32'h7777_1111);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Read that never completes is closed by the watchdog
    set_port(1, 1'b0, ADDR_W'(32'h500), 32'h0, 4'hF);
    tick();
    check("tmo_grant", grant, 2'b10);
    tick();
    for (int i = 0; i < TMO; i++) begin
      check("tmo_wait_noack", acks, 0);
      check("tmo_wait_flag", timeout_err, 0);
      tick();
    end
    check("tmo_ack", acks, 2'b10);
    check("tmo_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("tmo_flag", timeout_err, 1);
    exp_rd[1] = 32'hDEAD_BEEF;
    last_srv  = 1;
    p_req[1]  = 1'b0;
    tick();
    check("tmo_sticky_idle", timeout_err, 1);
    set_port(0, 1'b1, ADDR_W'(32'h504), 32'h1357_9BDF, 4'hF);
    transact(0, 0, 0, '0);
    check("tmo_sticky_later", timeout_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("tmo_cleared", timeout_err, 0);
`else
    // Without the watchdog a slow read simply waits
    set_port(1, 1'b0, ADDR_W'(32'h500), 32'h0, 4'hF);
    transact(0, 40, 0, 32'h2468_ACE0);
    check("no_tmo_flag", timeout_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang required completion");
    $fatal(1, "time limit");
  end

endmodule
